// File: rtl/sdlc_mul_pipe_pkg.sv
// Shared definitions for the SDLC multiplier pipeline: mode encodings,
// product-width helper and a scalar SDLC reference function.
package sdlc_pkg;

    localparam logic MODE_EXACT = 1'b0;
    localparam logic MODE_SDLC  = 1'b1;

    function automatic int PW(input int w);
        return 2 * w;
    endfunction

    // Bit-level SDLC product for operand width w (w even, 4..32).
    function automatic logic [63:0] sdlc_model(input logic [31:0] x, input logic [31:0] y, input int w);
        logic [63:0] acc;
        logic [63:0] a;
        logic [63:0] b;
        logic        bit_v;
        int          m;
        acc = 64'd0;
        for (int k = 0; k < w / 2; k++) begin
            a = x[2*k]   ? {32'd0, y} : 64'd0;
            b = x[2*k+1] ? {32'd0, y} : 64'd0;
            m = w - 1 - k;
            for (int j = 0; j <= m + 1; j++) begin
                bit_v = (j == 0) ? a[0] : ((j == m + 1) ? b[m] : (a[j] | b[j-1]));
                acc = acc + ({63'd0, bit_v} << (2 * k + j));
            end
            for (int i = m + 1; i < w; i++) begin
                acc = acc + ({63'd0, a[i]} << (2 * k + i));
                acc = acc + ({63'd0, b[i]} << (2 * k + 1 + i));
            end
        end
        return acc & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

endpackage

// File: rtl/sdlc_pair_compress.sv
// Compresses partial-product rows 2K and 2K+1 into one OR-merged row plus the
// exact tail bits that sit in the triangular exact region on the MSB side.
module sdlc_pair_compress #(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] comp,
    output logic [2*WIDTH-1:0] exact
);

    localparam int M   = WIDTH - 1 - K;
    localparam int OFF = 2 * K;

    // The b tail starts just above the merged row, so it shares the comp vector;
    // the a tail overlaps b[M] and therefore needs its own vector.
    always_comb begin
        comp  = {(2*WIDTH){1'b0}};
        exact = {(2*WIDTH){1'b0}};
        comp[OFF] = a[0];
        for (int j = 1; j <= M; j++) begin
            comp[OFF+j] = a[j] | b[j-1];
        end
        comp[OFF+M+1] = b[M];
        for (int i = M + 1; i < WIDTH; i++) begin
            exact[OFF+i]   = a[i];
            comp[OFF+1+i]  = b[i];
        end
    end

endmodule

// File: rtl/sdlc_mul_pipe.sv
// Three-stage valid/ready multiplier: operand capture, row select + CSA
// reduction, final carry-propagate add. Each beat is exact or SDLC.
module sdlc_mul_pipe
    import sdlc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_z,
    output logic               out_mode
);

    localparam int PROD_W = PW(WIDTH);

    logic                          v1_r, v2_r, v3_r;
    logic                          load1_s, load2_s, load3_s;
    logic [WIDTH-1:0]              x1_r, y1_r;
    logic                          mode1_r, mode2_r;
    logic [PROD_W-1:0]             sum2_r, carry2_r;
    logic [WIDTH-1:0][PROD_W-1:0]  exact_rows_s, sdlc_rows_s, rows_s;
    logic [PROD_W-1:0]             sum_s, carry_s, maj_s;

    // Stall chain: a stage loads when empty or when the stage below is loading.
    always_comb begin
        load3_s = ~v3_r | out_ready;
        load2_s = ~v2_r | load3_s;
        load1_s = ~v1_r | load2_s;
    end

    assign in_ready  = load1_s;
    assign out_valid = v3_r;

    genvar g;
    generate
        for (g = 0; g < WIDTH / 2; g++) begin : g_pair
            logic [WIDTH-1:0] a_s, b_s;
            assign a_s = y1_r & {WIDTH{x1_r[2*g]}};
            assign b_s = y1_r & {WIDTH{x1_r[2*g+1]}};
            sdlc_pair_compress #(.WIDTH(WIDTH), .K(g)) u_pair (
                .a     (a_s),
                .b     (b_s),
                .comp  (sdlc_rows_s[2*g]),
                .exact (sdlc_rows_s[2*g+1])
            );
        end
    endgenerate

    // Both modes present exactly WIDTH rows, so one CSA array serves either set.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            exact_rows_s[i] = {{WIDTH{1'b0}}, y1_r & {WIDTH{x1_r[i]}}} << i;
            rows_s[i]       = (mode1_r == MODE_SDLC) ? sdlc_rows_s[i] : exact_rows_s[i];
        end
    end

    // Carry-save reduction of the selected rows to a sum/carry pair.
    always_comb begin
        sum_s   = rows_s[0];
        carry_s = rows_s[1];
        maj_s   = {PROD_W{1'b0}};
        for (int i = 2; i < WIDTH; i++) begin
            maj_s   = (sum_s & carry_s) | (sum_s & rows_s[i]) | (carry_s & rows_s[i]);
            sum_s   = sum_s ^ carry_s ^ rows_s[i];
            carry_s = {maj_s[PROD_W-2:0], 1'b0};
        end
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            x1_r    <= {WIDTH{1'b0}};
            y1_r    <= {WIDTH{1'b0}};
            mode1_r <= MODE_EXACT;
        end else if (load1_s) begin
            v1_r    <= in_valid;
            x1_r    <= in_x;
            y1_r    <= in_y;
            mode1_r <= in_mode;
        end
    end

    // Stage 2: reduced sum/carry vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r     <= 1'b0;
            sum2_r   <= {PROD_W{1'b0}};
            carry2_r <= {PROD_W{1'b0}};
            mode2_r  <= MODE_EXACT;
        end else if (load2_s) begin
            v2_r     <= v1_r;
            sum2_r   <= sum_s;
            carry2_r <= carry_s;
            mode2_r  <= mode1_r;
        end
    end

    // Stage 3: final carry-propagate add into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r     <= 1'b0;
            out_z    <= {PROD_W{1'b0}};
            out_mode <= MODE_EXACT;
        end else if (load3_s) begin
            v3_r     <= v2_r;
            out_z    <= sum2_r + carry2_r;
            out_mode <= mode2_r;
        end
    end

endmodule
